determine_hit: RTL and testbench
================================

Name: determine_hit

Overview:
- Hit/victim-select logic for the 4-entry, fully associative, LRU data cache.
- Compares the incoming address against all four tag entries and reports hit/miss.
- Selects the matching entry on a hit, or the replacement victim on a miss.
- Flags which LRU counters the cache controller must decrement.
- Purely combinational datapath, plus a registered copy of the result for pipelined or debug use.

Parameters:
- a_width, 8, width of the address and of each stored tag.

Ports:
- clk  input  1  rising-edge clock for the registered result copies.
- clr  input  1  synchronous reset, active-high; clears the registered copies only.
- addr_in  input  a_width  lookup address.
- w_addr  input  4*a_width  packed tags; entry i at bits [i*a_width +: a_width].
- w_cnt  input  8  packed 2-bit LRU counters; entry i at bits [2i+1:2i]; 3 = most recently used, 0 = least recently used.
- valid  input  4  valid[i]=1 means entry i holds live data.
- sel  output  2  hit: matching entry index; miss: victim index.
- dec  output  4  dec[i]=1 means counter i must be decremented.
- hit  output  1  1 = hit, 0 = miss.
- hit_r  output  1  registered hit.
- sel_r  output  2  registered sel.
- dec_r  output  4  registered dec.

Behaviour:
- hit, sel and dec are combinational: zero latency, settle within the same cycle addr_in changes.
- Match: match[i] = valid[i] AND (tag i == addr_in); compare all a_width bits.
  - Invalid entries never match, even when the tag equals addr_in (e.g. tags reset to 0 and addr_in=0 gives a miss).
- hit = OR of match[3:0].
- sel on hit: lowest index i with match[i]=1. The controller never creates duplicates, but the priority is defined.
- sel on miss, in priority order:
  - lowest-index invalid entry, if any entry is invalid;
  - otherwise the lowest-index entry with cnt==0;
  - otherwise the lowest-index entry holding the minimum counter value.
- The controller uses valid[sel] on a miss to decide whether write-back is needed. sel must therefore point at an invalid entry whenever one exists.
- dec on hit: dec[i] = valid[i] AND (cnt[i] > cnt[sel]), unsigned compare.
  - dec[sel] is always 0.
  - A counter flagged by dec is never 0, so a decrement cannot underflow.
- dec on miss: dec[i] = valid[i] AND (cnt[i] != 0).
- No arithmetic on the counters inside this block; the controller performs decrements and sets cnt[sel]=3.
- Registered copies, updated on the rising edge of clk:
  - clr=1 gives hit_r=0, sel_r=0, dec_r=0;
  - otherwise hit_r<=hit, sel_r<=sel, dec_r<=dec.
  - clr has priority over all else; a reset mid-operation affects only the registered copies, never the combinational outputs.
- Power-up and reset values: hit_r=0, sel_r=0, dec_r=0. Combinational outputs follow their inputs at all times.
- No X propagation: every output is fully defined for all input combinations, including valid=0000, where the result is hit=0, sel=0, dec=0000.

Test Plan:
- valid=0000, all tags 0, addr_in=0x00 -> hit=0, sel=0, dec=0000.
- valid=0011, tags {e0=0x10, e1=0x20}, cnt {e0=3, e1=2}, addr_in=0x30 -> hit=0, sel=2, dec=0011.
- valid=1111, tags {0x10,0x20,0x30,0x40}, cnt {e0=0,e1=1,e2=2,e3=3}, addr_in=0x20 -> hit=1, sel=1, dec=1100.
- Same entries, addr_in=0x55 -> hit=0, sel=0 (the cnt==0 entry), dec=1110.
- valid=1011, tag of e2=0x30 (invalid), addr_in=0x30 -> hit=0, sel=2.
- Apply a hit (sel=3), then clr=1 for one clock -> hit_r=0, sel_r=0, dec_r=0000, while combinational hit stays 1. Release clr -> hit_r=1, sel_r=3 after the next edge.

Source files
------------

// File: rtl/determine_hit.sv
// Hit detection and victim selection for a 4-entry fully associative LRU cache.
// The lookup result is combinational; a registered copy is kept for pipelined or debug use.
module determine_hit #(
  parameter int unsigned a_width = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [a_width-1:0]   addr_in,
  input  logic [4*a_width-1:0] w_addr,
  input  logic [7:0]           w_cnt,
  input  logic [3:0]           valid,
  output logic [1:0]           sel,
  output logic [3:0]           dec,
  output logic                 hit,
  output logic                 hit_r,
  output logic [1:0]           sel_r,
  output logic [3:0]           dec_r
);

  localparam int unsigned n_entries = 4;
  localparam int unsigned cnt_w     = 2;

  logic [n_entries-1:0] match;
  logic [cnt_w-1:0]     cnt [n_entries];
  logic [1:0]           hit_idx;
  logic [1:0]           inv_idx;
  logic                 any_inv;
  logic [1:0]           min_idx;
  logic [cnt_w-1:0]     min_cnt;
  logic [cnt_w-1:0]     sel_cnt;

  // Tag compare; an invalid entry never matches regardless of its stored tag.
  always_comb begin
    match = '0;
    for (int i = 0; i < int'(n_entries); i++) begin
      cnt[i]   = w_cnt[cnt_w*i +: cnt_w];
      match[i] = valid[i] && (w_addr[a_width*i +: a_width] == addr_in);
    end
  end

  // Lowest-index priority encoders for match and invalid entries.
  always_comb begin
    hit_idx = 2'd0;
    inv_idx = 2'd0;
    any_inv = 1'b0;
    for (int i = int'(n_entries) - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = 2'(i);
      if (!valid[i]) begin
        inv_idx = 2'(i);
        any_inv = 1'b1;
      end
    end
  end

  // Lowest-index minimum counter; a zero counter is the minimum, so it wins when present.
  always_comb begin
    min_idx = 2'd0;
    min_cnt = cnt[0];
    for (int i = 1; i < int'(n_entries); i++) begin
      if (cnt[i] < min_cnt) begin
        min_idx = 2'(i);
        min_cnt = cnt[i];
      end
    end
  end

  always_comb begin
    hit = |match;
    if (hit)          sel = hit_idx;
    else if (any_inv) sel = inv_idx;
    else              sel = min_idx;
  end

  // Age everything newer than the hit entry; on a miss age every live non-zero counter.
  always_comb begin
    dec     = '0;
    sel_cnt = cnt[sel];
    for (int i = 0; i < int'(n_entries); i++) begin
      if (hit) dec[i] = valid[i] && (cnt[i] > sel_cnt);
      else     dec[i] = valid[i] && (cnt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      hit_r <= 1'b0;
      sel_r <= 2'd0;
      dec_r <= 4'd0;
    end else begin
      hit_r <= hit;
      sel_r <= sel;
      dec_r <= dec;
    end
  end

endmodule

// File: tb/tb_determine_hit.sv
// Scoreboard bench for determine_hit: driver pushes model results, monitor checks
// both the combinational outputs and their registered copies.
module tb_determine_hit;

  typedef struct packed {
    logic       clr;
    logic       hit;
    logic [1:0] sel;
    logic [3:0] dec;
  } exp_t;

  logic        clk;
  logic        clr;
  logic [7:0]  addr_in;
  logic [31:0] w_addr;
  logic [7:0]  w_cnt;
  logic [3:0]  valid;
  logic [1:0]  sel;
  logic [3:0]  dec;
  logic        hit;
  logic        hit_r;
  logic [1:0]  sel_r;
  logic [3:0]  dec_r;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  determine_hit #(.a_width(8)) dut (
    .clk(clk), .clr(clr), .addr_in(addr_in), .w_addr(w_addr), .w_cnt(w_cnt),
    .valid(valid), .sel(sel), .dec(dec), .hit(hit),
    .hit_r(hit_r), .sel_r(sel_r), .dec_r(dec_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: hit search, then victim by invalid / zero counter / minimum counter.
  function automatic exp_t model(input logic c, input logic [7:0] a, input logic [31:0] tg,
                                 input logic [7:0] ct, input logic [3:0] v);
    exp_t r;
    int   cn [4];
    int   min_v;
    int   first_inv;
    int   first_zero;
    int   pick;
    r = '0;
    r.clr = c;
    for (int i = 0; i < 4; i++) cn[i] = int'(ct[2*i +: 2]);
    for (int i = 0; i < 4; i++)
      if (!r.hit && v[i] && tg[8*i +: 8] == a) begin
        r.hit = 1'b1;
        r.sel = 2'(i);
      end
    if (r.hit) begin
      for (int i = 0; i < 4; i++) r.dec[i] = v[i] && (cn[i] > cn[int'(r.sel)]);
    end else begin
      first_inv  = -1;
      first_zero = -1;
      min_v      = 99;
      for (int i = 0; i < 4; i++) begin
        if (!v[i] && first_inv < 0) first_inv = i;
        if (cn[i] == 0 && first_zero < 0) first_zero = i;
        if (cn[i] < min_v) min_v = cn[i];
      end
      pick = -1;
      if (first_inv >= 0) pick = first_inv;
      else if (first_zero >= 0) pick = first_zero;
      else
        for (int i = 0; i < 4; i++) if (pick < 0 && cn[i] == min_v) pick = i;
      r.sel = 2'(pick);
      for (int i = 0; i < 4; i++) r.dec[i] = v[i] && (cn[i] != 0);
    end
    return r;
  endfunction

  task automatic drive(input logic c, input logic [7:0] a, input logic [31:0] tg,
                       input logic [7:0] ct, input logic [3:0] v);
    @(negedge clk);
    clr     = c;
    addr_in = a;
    w_addr  = tg;
    w_cnt   = ct;
    valid   = v;
    exp_q.push_back(model(c, a, tg, ct, v));
  endtask

  // Monitor: the item driven before this edge is both visible combinationally and just clocked.
  initial begin
    exp_t e;
    logic [6:0] reg_exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({hit, sel, dec} !== {e.hit, e.sel, e.dec}) begin
          errors++;
          $display("FAIL comb: got hit=%b sel=%0d dec=%b, expected hit=%b sel=%0d dec=%b",
                   hit, sel, dec, e.hit, e.sel, e.dec);
        end
        reg_exp = e.clr ? 7'd0 : {e.hit, e.sel, e.dec};
        checks++;
        if ({hit_r, sel_r, dec_r} !== reg_exp) begin
          errors++;
          $display("FAIL reg: got hit_r=%b sel_r=%0d dec_r=%b, expected %b (clr=%b)",
                   hit_r, sel_r, dec_r, reg_exp, e.clr);
        end
      end
    end
  end

  initial begin
    logic [31:0] tg;
    logic [7:0]  ct;
    logic [3:0]  v;
    logic [7:0]  a;
    logic        c;
    clr = 1'b1; addr_in = '0; w_addr = '0; w_cnt = '0; valid = '0;

    // Directed cases: reset/empty, partial fill, hit, full miss, invalid tag match, clr window.
    drive(1'b1, 8'h00, 32'h0, 8'h00, 4'b0000);
    drive(1'b0, 8'h00, 32'h0, 8'h00, 4'b0000);
    drive(1'b0, 8'h30, 32'h0000_2010, 8'h0B, 4'b0011);
    drive(1'b0, 8'h20, 32'h4030_2010, 8'hE4, 4'b1111);
    drive(1'b0, 8'h55, 32'h4030_2010, 8'hE4, 4'b1111);
    drive(1'b0, 8'h30, 32'h4030_2010, 8'hE4, 4'b1011);
    drive(1'b0, 8'h40, 32'h4030_2010, 8'hE4, 4'b1111);
    drive(1'b1, 8'h40, 32'h4030_2010, 8'hE4, 4'b1111);
    drive(1'b0, 8'h40, 32'h4030_2010, 8'hE4, 4'b1111);
    // Full set, no zero counter: minimum-counter fallback.
    drive(1'b0, 8'h99, 32'h4030_2010, 8'b01_10_01_11, 4'b1111);
    // Duplicate tags: lowest matching index wins.
    drive(1'b0, 8'h20, 32'h2020_2010, 8'b11_01_10_00, 4'b1110);

    // Random: narrow tag range forces frequent hits, duplicates and invalid matches.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) tg[8*i +: 8] = 8'($urandom_range(0, 7));
      ct = 8'($urandom);
      v  = 4'($urandom);
      if ($urandom_range(0, 3) == 0) v = 4'hF;
      a  = 8'($urandom_range(0, 8));
      c  = ($urandom_range(0, 15) == 0);
      drive(c, a, tg, ct, v);
    end

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #2;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d items left unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
